// File: rtl/rst_seq_gen.sv
`default_nettype none
// rst_seq_gen: conditions PLL lock and a push-button, then releases NUM_CHAN resets in staggered order.
// Optional watchdog restart is compiled in with macro RST_SEQ_WDT_EN.
module rst_seq_gen #(
  parameter int NUM_CHAN        = 3,
  parameter int HOLD_CYCLES     = 1024,
  parameter int STAGGER_CYCLES  = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int WDT_CYCLES      = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pll_locked,
  input  logic                key_n,
  input  logic                wdt_kick,
  output logic [NUM_CHAN-1:0] rst_o,
  output logic                ready,
  output logic [1:0]          state_o,
  output logic                wdt_fired
);

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_STAGGER = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam int CW = (HW > SW) ? HW : SW;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int IW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_PEN   = IW'((NUM_CHAN > 1) ? NUM_CHAN - 2 : 0);

  logic          lock_m, lock_s, key_m, key_s, key_db;
  logic [DW-1:0] db_cnt;
  logic          wdt_timeout;
  logic          fault;

  logic [1:0]          state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [NUM_CHAN-1:0] rst_nxt;
  logic                ready_nxt;

  // Two-flop synchronisers, then a debouncer that flips only after a full run of differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      key_m  <= 1'b1;
      key_s  <= 1'b1;
      key_db <= 1'b1;
      db_cnt <= '0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
      key_m  <= key_n;
      key_s  <= key_m;
      if (key_s == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign fault = !lock_s || !key_db || wdt_timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_ASSERT;
      cnt   <= '0;
      idx   <= '0;
      rst_o <= '1;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      rst_o <= rst_nxt;
      ready <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    idx_nxt   = idx;
    if (fault) begin
      state_nxt = ST_ASSERT;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_ASSERT: begin
          state_nxt = ST_HOLD;
          idx_nxt   = '0;
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            idx_nxt   = '0;
            state_nxt = (NUM_CHAN == 1) ? ST_RUN : ST_STAGGER;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_STAGGER: begin
          if (cnt == STAG_LAST) begin
            idx_nxt = idx + IW'(1);
            if (idx == IDX_PEN) state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_RUN:  state_nxt = ST_RUN;
        default: state_nxt = ST_ASSERT;
      endcase
    end
  end

  // Channels 0..idx are released while staggering, so release order stays monotonic.
  always_comb begin
    rst_nxt   = '1;
    ready_nxt = 1'b0;
    case (state_nxt)
      ST_STAGGER: begin
        for (int k = 0; k < NUM_CHAN; k++) rst_nxt[k] = (k > int'(idx_nxt));
      end
      ST_RUN: begin
        rst_nxt   = '0;
        ready_nxt = 1'b1;
      end
      default: rst_nxt = '1;
    endcase
  end

  assign state_o = state;

`ifdef RST_SEQ_WDT_EN
  localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt_cnt;

  // A kick on the terminal cycle suppresses the timeout.
  assign wdt_timeout = (state == ST_RUN) && !wdt_kick && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      wdt_cnt   <= '0;
      wdt_fired <= 1'b0;
    end else begin
      if ((state != ST_RUN) || wdt_kick || wdt_timeout) wdt_cnt <= '0;
      else                                              wdt_cnt <= wdt_cnt + WW'(1);
      if (wdt_timeout) wdt_fired <= 1'b1;
    end
  end
`else
  logic unused_kick;
  assign unused_kick = wdt_kick;
  assign wdt_timeout = 1'b0;
  assign wdt_fired   = 1'b0;
`endif

endmodule
`default_nettype wire
